// File: rtl/toggle_bus_checker.sv
// Checks a bus of free-running 1-bit toggle counters against the expected alternating phase.
// Optional saturating mismatch counter on err_cnt is enabled with `define TOGGLE_CHK_ERRCNT_EN.
module toggle_bus_checker #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5
`ifdef TOGGLE_CHK_ERRCNT_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic             c,
   input  logic             r,
   input  logic [WIDTH-1:0] a,
   input  logic             clr,
   output logic             ok,
   output logic             fault,
   output logic [WIDTH-1:0] err_mask,
   output logic [IDX_W-1:0] first_err_idx
`ifdef TOGGLE_CHK_ERRCNT_EN
   ,
   output logic [CNT_W-1:0] err_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_FAULT  = 2'd2,
      ST_RESYNC = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic               exp_q, exp_d;
   logic               ok_q, ok_d;
   logic               fault_q, fault_d;
   logic [WIDTH-1:0]   err_mask_q, err_mask_d;
   logic [IDX_W-1:0]   first_err_idx_q, first_err_idx_d;
   logic [WIDTH-1:0]   mm;
   logic [IDX_W-1:0]   mm_idx;
   logic               cmp_err;

   assign mm = a ^ {WIDTH{exp_q}};

   // Scan from the top so the lowest mismatching bit is the one left standing.
   always_comb begin
      mm_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (mm[i]) mm_idx = IDX_W'(i);
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      state_d         = state_q;
      exp_d           = ~exp_q;
      err_mask_d      = err_mask_q;
      first_err_idx_d = first_err_idx_q;
      cmp_err         = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_CHECK: begin
            if (|mm) begin
               cmp_err         = 1'b1;
               state_d         = ST_FAULT;
               err_mask_d      = err_mask_q | mm;
               first_err_idx_d = mm_idx;
            end else begin
               state_d = ST_CHECK;
            end
         end
         ST_FAULT: begin
            if (clr) begin
               state_d         = ST_RESYNC;
               err_mask_d      = '0;
               first_err_idx_d = '0;
            end
         end
         ST_RESYNC: begin
            // Adopt the bus phase: bit 0 flips at this edge, so expect its inverse next.
            exp_d   = ~a[0];
            state_d = ST_CHECK;
         end
         default: begin
            state_d = ST_IDLE;
            exp_d   = 1'b0;
         end
      endcase
      ok_d    = (state_d == ST_CHECK);
      fault_d = (state_d == ST_FAULT);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge c) begin
      if (r) begin
         state_q         <= ST_IDLE;
         exp_q           <= 1'b0;
         ok_q            <= 1'b0;
         fault_q         <= 1'b0;
         err_mask_q      <= '0;
         first_err_idx_q <= '0;
      end else begin
         state_q         <= state_d;
         exp_q           <= exp_d;
         ok_q            <= ok_d;
         fault_q         <= fault_d;
         err_mask_q      <= err_mask_d;
         first_err_idx_q <= first_err_idx_d;
      end
   end

   assign ok            = ok_q;
   assign fault         = fault_q;
   assign err_mask      = err_mask_q;
   assign first_err_idx = first_err_idx_q;

`ifdef TOGGLE_CHK_ERRCNT_EN
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (cmp_err && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge c) begin
      if (r) err_cnt_q <= '0;
      else   err_cnt_q <= err_cnt_d;
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule
